// File: rtl/prog_loader.sv
// prog_loader: receives a framed program image from a host byte stream and
// writes it into the CPU's instruction memory, holding the CPU in reset until
// a complete frame has been received and its checksum verified.
//
// Frame: SYNC_BYTE, length N (1..DEPTH), N instruction bytes, then a checksum
// equal to the sum of the N instruction bytes mod 256.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   host byte valid
//   in_data    host byte
//   in_ready   loader can accept a byte (low only during reset)
//   imem_we    instruction memory write strobe, one cycle per instruction byte
//   imem_addr  instruction memory write address
//   imem_data  instruction byte to write
//   cpu_rst    held reset to the CPU, low only when a verified program is loaded
//   busy       frame reception in progress
//   done       last frame loaded and verified
//   err        0 none, 1 bad length, 2 checksum mismatch, 3 timeout
//
// DEPTH must not exceed 16, the reach of the 4-bit imem_addr.

module prog_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         DEPTH     = 16,
  parameter int         TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       imem_we,
  output logic [3:0] imem_addr,
  output logic [7:0] imem_data,
  output logic       cpu_rst,
  output logic       busy,
  output logic       done,
  output logic [1:0] err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    E_NONE    = 2'd0,
    E_LEN     = 2'd1,
    E_CSUM    = 2'd2,
    E_TIMEOUT = 2'd3
  } err_t;

  localparam int            IW        = $clog2(TIMEOUT + 1);
  localparam logic [8:0]    DEPTH_W   = 9'(DEPTH);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  state_t        state;
  logic [7:0]    len;       // frame length N
  logic [7:0]    cnt;       // index of the next instruction byte
  logic [7:0]    csum;      // running sum of instruction bytes
  logic [IW-1:0] idle_cnt;  // cycles since the last accepted byte in a frame

  logic accept;
  logic len_ok;

  // in_ready is a register, so accept never depends combinationally on
  // anything but the host's own valid.
  assign accept = in_valid && in_ready;
  assign len_ok = (in_data != 8'd0) && ({1'b0, in_data} <= DEPTH_W);

  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values of each other; a blocking = would let later statements
  // see the new state within the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      imem_we   <= 1'b0;
      imem_addr <= 4'd0;
      imem_data <= 8'd0;
      cpu_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= E_NONE;
      len       <= 8'd0;
      cnt       <= 8'd0;
      csum      <= 8'd0;
      idle_cnt  <= '0;
    end else begin
      in_ready <= 1'b1;
      imem_we  <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          // Anything other than the sync marker is consumed and dropped.
          if (accept && in_data == SYNC_BYTE) begin
            state    <= S_LEN;
            err      <= E_NONE;
            done     <= 1'b0;
            cpu_rst  <= 1'b1;
            busy     <= 1'b1;
            csum     <= 8'd0;
            cnt      <= 8'd0;
            idle_cnt <= '0;
          end
        end

        S_LEN, S_DATA, S_CSUM: begin
          if (accept) begin
            idle_cnt <= '0;
            case (state)
              S_LEN: begin
                if (len_ok) begin
                  len   <= in_data;
                  state <= S_DATA;
                end else begin
                  state <= S_ERR;
                  err   <= E_LEN;
                  busy  <= 1'b0;
                end
              end
              S_DATA: begin
                imem_we   <= 1'b1;
                imem_addr <= cnt[3:0];
                imem_data <= in_data;
                csum      <= csum + in_data;
                cnt       <= cnt + 8'd1;
                if (cnt == len - 8'd1) state <= S_CSUM;
              end
              default: begin  // S_CSUM
                busy <= 1'b0;
                if (in_data == csum) begin
                  state   <= S_DONE;
                  done    <= 1'b1;
                  cpu_rst <= 1'b0;
                end else begin
                  state <= S_ERR;
                  err   <= E_CSUM;
                end
              end
            endcase
          end else if (idle_cnt == IDLE_LAST) begin
            // TIMEOUT consecutive edges without an accepted byte.
            state <= S_ERR;
            err   <= E_TIMEOUT;
            busy  <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
